trackball_quadrature: RTL

Converts PS/2 mouse packets from the HPS into the 4-bit trackball step stream the Centipede core samples on its trackball input. It sits directly upstream of the core's trackball input. It accumulates signed mouse deltas per axis and drains each accumulator at a fixed step rate. Each step produces one direction level and one toggling step bit per axis. Screen flip is honoured by inverting delta sign.

---
 rtl/trackball_quadrature.sv | 139 +++++++++++++
 1 files changed

// File: rtl/trackball_quadrature.sv
// PS/2 mouse deltas to Centipede trackball stream: per-axis saturating accumulators drained one step per tick.
// Define TRACKBALL_JOY_EN to add the joy_i port, which overrides the accumulators while a direction is held.
module trackball_quadrature #(
    parameter int STEP_DIV = 64,
    parameter int ACC_W    = 12
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        flip,
`ifdef TRACKBALL_JOY_EN
    input  logic [3:0]  joy_i,
`endif
    output logic [3:0]  trak_o,
    output logic        busy_o
);

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             dir;
        logic             step;
    } axis_t;

    localparam logic [11:0]      DIV_LAST = 12'(STEP_DIV - 1);
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // acc - s + delta evaluated two bits wider, then clamped so the accumulator never wraps
    function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W-1:0] acc,
                                                 input logic [1:0]       s,
                                                 input logic [ACC_W-1:0] delta);
        logic [ACC_W+1:0] sum;
        sum = {{2{acc[ACC_W-1]}}, acc} - {{ACC_W{s[1]}}, s} + {{2{delta[ACC_W-1]}}, delta};
        if (!sum[ACC_W+1] && (sum[ACC_W:ACC_W-1] != 2'b00)) begin
            sat_sum = ACC_MAX;
        end else if (sum[ACC_W+1] && (sum[ACC_W:ACC_W-1] != 2'b11)) begin
            sat_sum = ACC_MIN;
        end else begin
            sat_sum = sum[ACC_W-1:0];
        end
    endfunction

    // Sign-extended packet delta; flip negates it so the accumulated sign is frozen at accept time
    function automatic logic [ACC_W-1:0] mk_delta(input logic sgn, input logic [7:0] mag, input logic inv);
        logic [ACC_W-1:0] raw;
        raw = {{(ACC_W-8){sgn}}, mag};
        if (inv) begin
            mk_delta = ~raw + {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
            mk_delta = raw;
        end
    endfunction

    function automatic axis_t axis_next(input axis_t cur, input logic tick, input logic pos,
                                        input logic neg, input logic [ACC_W-1:0] delta);
        axis_t      nxt;
        logic [1:0] s;
        nxt = cur;
        s   = 2'b00;
        if (tick && (pos || neg)) begin
            // joystick owns the axis: accumulator is neither drained nor stepped from
            if (pos != neg) begin
                nxt.dir  = pos;
                nxt.step = ~cur.step;
            end else begin
                nxt.step = cur.step;
            end
        end else if (tick && (cur.acc != ACC_ZERO)) begin
            s        = cur.acc[ACC_W-1] ? 2'b11 : 2'b01;
            nxt.dir  = ~cur.acc[ACC_W-1];
            nxt.step = ~cur.step;
        end else begin
            s = 2'b00;
        end
        nxt.acc = sat_sum(cur.acc, s, delta);
        return nxt;
    endfunction

    logic             toggle_r;
    logic             armed_r;
    logic             busy_r;
    logic [11:0]      div_r;
    axis_t            ax_r;
    axis_t            ay_r;
    logic             tick_s;
    logic             pkt_s;
    logic [3:0]       joy_s;
    logic [ACC_W-1:0] dx_s;
    logic [ACC_W-1:0] dy_s;
    axis_t            ax_nxt_s;
    axis_t            ay_nxt_s;
    logic             unused_s;

`ifdef TRACKBALL_JOY_EN
    assign joy_s = joy_i;
`else
    assign joy_s = 4'b0000;
`endif
    assign unused_s = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

    // Packet/tick detection and next-state for both axes
    always_comb begin
        tick_s = (div_r == DIV_LAST);
        pkt_s  = armed_r & (toggle_r ^ ps2_mouse[24]);
        if (pkt_s) begin
            dx_s = mk_delta(ps2_mouse[4], ps2_mouse[15:8], flip);
            dy_s = mk_delta(ps2_mouse[5], ps2_mouse[23:16], flip);
        end else begin
            dx_s = ACC_ZERO;
            dy_s = ACC_ZERO;
        end
        ax_nxt_s = axis_next(ax_r, tick_s, joy_s[3], joy_s[2], dx_s);
        ay_nxt_s = axis_next(ay_r, tick_s, joy_s[1], joy_s[0], dy_s);
    end

    // State registers; armed_r masks a toggle bit already high when reset releases
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_r <= 1'b0;
            armed_r  <= 1'b0;
            div_r    <= 12'd0;
            ax_r     <= '{acc: ACC_ZERO, dir: 1'b0, step: 1'b0};
            ay_r     <= '{acc: ACC_ZERO, dir: 1'b0, step: 1'b0};
            busy_r   <= 1'b0;
        end else begin
            toggle_r <= ps2_mouse[24];
            armed_r  <= 1'b1;
            div_r    <= tick_s ? 12'd0 : div_r + 12'd1;
            ax_r     <= ax_nxt_s;
            ay_r     <= ay_nxt_s;
            busy_r   <= (ax_r.acc != ACC_ZERO) | (ay_r.acc != ACC_ZERO);
        end
    end

    assign trak_o = {ax_r.dir, ax_r.step, ay_r.dir, ay_r.step};
    assign busy_o = busy_r;

endmodule
